// File: rtl/spi_host_if.sv
// Request/response bus between a system-side requester and spi_host.
//   master modport : requester; drives req_valid/req_dir/req_addr/req_wdata,
//                    observes req_ready, rsp_valid, rsp_rdata, busy.
//   slave modport  : spi_host; drives req_ready, rsp_valid, rsp_rdata, busy.
interface spi_host_if #(
    parameter int unsigned SPI_ADDR_WIDTH = 3,
    parameter int unsigned SPI_DATA_WIDTH = 8
);
    logic                      req_valid;
    logic                      req_ready;
    logic                      req_dir;
    logic [SPI_ADDR_WIDTH-1:0] req_addr;
    logic [SPI_DATA_WIDTH-1:0] req_wdata;
    logic                      rsp_valid;
    logic [SPI_DATA_WIDTH-1:0] rsp_rdata;
    logic                      busy;

    modport master (
        output req_valid, req_dir, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, busy
    );

    modport slave (
        input  req_valid, req_dir, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, busy
    );
endinterface

// File: rtl/spi_host.sv
// SPI master: turns one bus request into one SPI frame (CPOL=1).
// Frame = SPI_CMD_WIDTH command bits (LSB first: dir, addr, zeros) followed by
// SPI_DATA_WIDTH data bits (MSB first). Read data is returned on a one-cycle
// rsp_valid strobe and held until the next one.
// Ports:
//   sys_clk, sys_rst_n : system clock, asynchronous active-low reset
//   bus (slave)        : req_valid/req_ready/req_dir/req_addr/req_wdata,
//                        rsp_valid/rsp_rdata, busy
//   spi_sel            : chip select, active low (registered)
//   spi_clk            : SPI clock, idles high (registered)
//   spi_mosi           : serial data out, changes on spi_clk falling edge
//   spi_miso           : serial data in, sampled on spi_clk rising edge
module spi_host #(
    parameter int unsigned SPI_CMD_WIDTH  = 8,
    parameter int unsigned SPI_DATA_WIDTH = 8,
    parameter int unsigned SPI_ADDR_WIDTH = 3,
    parameter int unsigned CLK_DIV        = 2
) (
    input  logic      sys_clk,
    input  logic      sys_rst_n,
    spi_host_if.slave bus,
    output logic      spi_sel,
    output logic      spi_clk,
    output logic      spi_mosi,
    input  logic      spi_miso
);
    localparam int unsigned FrameLen = SPI_CMD_WIDTH + SPI_DATA_WIDTH;
    localparam int unsigned HpWidth  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BitWidth = $clog2(FrameLen);

    typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StDone} state_e;

    state_e                    state_q;
    logic [HpWidth-1:0]        hp_q;
    logic [BitWidth-1:0]       bit_q;
    logic [FrameLen-1:0]       tx_q;
    logic [SPI_DATA_WIDTH-1:0] rx_q;
    logic [SPI_DATA_WIDTH-1:0] rdata_q;
    logic                      dir_q;
    logic                      rsp_valid_q;

    logic [SPI_CMD_WIDTH-1:0]  cmd;
    logic [SPI_CMD_WIDTH-1:0]  cmd_rev;
    logic                      hp_last;

    // Command is sent LSB first while data goes MSB first; reversing the command
    // lets the whole frame leave from the top of a single shift register.
    always_comb begin
        cmd                   = '0;
        cmd[0]                = bus.req_dir;
        cmd[SPI_ADDR_WIDTH:1] = bus.req_addr;
        cmd_rev               = '0;
        for (int i = 0; i < int'(SPI_CMD_WIDTH); i++) begin
            cmd_rev[i] = cmd[SPI_CMD_WIDTH-1-i];
        end
    end

    assign hp_last = (hp_q == HpWidth'(CLK_DIV - 1));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= StIdle;
            hp_q        <= '0;
            bit_q       <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            rdata_q     <= '0;
            dir_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            spi_sel     <= 1'b1;
            spi_clk     <= 1'b1;
            spi_mosi    <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.req_valid) begin
                        state_q <= StSetup;
                        spi_sel <= 1'b0;
                        hp_q    <= '0;
                        bit_q   <= '0;
                        dir_q   <= bus.req_dir;
                        rx_q    <= '0;
                        tx_q    <= {cmd_rev,
                                    bus.req_dir ? bus.req_wdata : {SPI_DATA_WIDTH{1'b0}}};
                    end
                end
                StSetup: begin
                    if (hp_last) begin
                        hp_q     <= '0;
                        state_q  <= StShift;
                        spi_clk  <= 1'b0;
                        spi_mosi <= tx_q[FrameLen-1];
                        tx_q     <= {tx_q[FrameLen-2:0], 1'b0};
                    end else begin
                        hp_q <= hp_q + HpWidth'(1);
                    end
                end
                StShift: begin
                    if (!hp_last) begin
                        hp_q <= hp_q + HpWidth'(1);
                    end else begin
                        hp_q <= '0;
                        if (!spi_clk) begin
                            // End of low phase: rising edge, sample data bits only.
                            spi_clk <= 1'b1;
                            if (bit_q >= BitWidth'(SPI_CMD_WIDTH)) begin
                                rx_q <= {rx_q[SPI_DATA_WIDTH-2:0], spi_miso};
                            end
                        end else if (bit_q == BitWidth'(FrameLen - 1)) begin
                            state_q <= StHold;
                        end else begin
                            bit_q    <= bit_q + BitWidth'(1);
                            spi_clk  <= 1'b0;
                            spi_mosi <= tx_q[FrameLen-1];
                            tx_q     <= {tx_q[FrameLen-2:0], 1'b0};
                        end
                    end
                end
                StHold: begin
                    if (hp_last) begin
                        state_q     <= StDone;
                        spi_sel     <= 1'b1;
                        spi_mosi    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rdata_q     <= dir_q ? {SPI_DATA_WIDTH{1'b0}} : rx_q;
                    end else begin
                        hp_q <= hp_q + HpWidth'(1);
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.req_ready = (state_q == StIdle);
    assign bus.busy      = (state_q != StIdle);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rdata_q;
endmodule
